// File: rtl/noc_input_fifo.sv
// -----------------------------------------------------------------------------
// noc_input_fifo
//
// Per-port input buffer of the NoC router. Flits arrive from the neighbouring
// router over an RTS/CTS handshake, are held in a circular FIFO, and the head
// flit is presented to the crossbar. Any output arbiter granting this input
// port pops the head flit.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset; clears pointers, count, CTS and
//              every memory entry
//   RX         incoming flit, held stable by upstream while DRTS is high
//   DRTS       upstream request-to-send
//   read_en_*  grants from the N/E/W/S/L output arbiters (one-hot expected)
//   CTS        registered clear-to-send pulse back to upstream
//   Data_out   head flit, first-word-fall-through (stale when empty)
//   empty      no valid entries
//   full       DEPTH valid entries
//   count      number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module noc_input_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4    // power of 2, minimum 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   RX,
   input  logic                    DRTS,
   input  logic                    read_en_N,
   input  logic                    read_en_E,
   input  logic                    read_en_W,
   input  logic                    read_en_S,
   input  logic                    read_en_L,
   output logic                    CTS,
   output logic [DATA_WIDTH-1:0]   Data_out,
   output logic                    empty,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      write_ptr;
   logic [PTR_W-1:0]      read_ptr;

   logic                  read_req;
   logic                  read_en_fire;
   logic                  cts_next;

   // Flags and handshake decisions look only at current state: a pop in the
   // same cycle does not make room for a write (no bypass path).
   always_comb begin
      // NOTE: every signal written here is assigned on every pass through the
      // block, so no path can leave one holding its old value (no latch).
      empty        = (count == '0);
      full         = (count == CNT_W'(DEPTH));
      read_req     = read_en_N | read_en_E | read_en_W | read_en_S | read_en_L;
      read_en_fire = read_req & ~empty;
      // CTS is a one-cycle pulse: a write is accepted only while CTS is low,
      // which gives upstream a cycle to drop DRTS before it could re-trigger.
      cts_next     = DRTS & ~CTS & ~full;
   end

   assign Data_out = mem[read_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         write_ptr <= '0;
         read_ptr  <= '0;
         count     <= '0;
         CTS       <= 1'b0;
         // NOTE: the storage array is reset as well so Data_out reads zero
         // after reset instead of leftover flits from before the reset.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         // NOTE: all state here uses non-blocking assignments so every
         // register samples the pre-edge values, independent of statement order.
         CTS <= cts_next;

         if (cts_next) begin
            mem[write_ptr] <= RX;
            write_ptr      <= write_ptr + PTR_W'(1);   // wraps at DEPTH
         end

         if (read_en_fire) begin
            read_ptr <= read_ptr + PTR_W'(1);          // wraps at DEPTH
         end

         case ({cts_next, read_en_fire})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;                   // idle, or push+pop
         endcase
      end
   end

endmodule
